// File: rtl/sdram_bus_bridge.sv
// sdram_bus_bridge: kernel SDRAM bus (stb/we/sel/ack) to sdram_top (rd_req/wr_req/ack) with delayed ctl reset, DQM, read capture, delayed ack and timeout
module sdram_bus_bridge #(
  parameter int RST_DELAY = 3,
  parameter int ACK_DELAY = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk_p,
  input  logic        sdram_reset,
  input  logic        sdram_stb,
  input  logic        sdram_we,
  input  logic [1:0]  sdram_sel,
  input  logic [20:0] sdram_adr,
  input  logic [15:0] sdram_out,
  output logic [15:0] sdram_dat,
  output logic        sdram_ack,
  output logic        sdram_ready,
  output logic        ctl_rst_n,
  output logic        ctl_wr_req,
  output logic        ctl_rd_req,
  input  logic        ctl_wr_ack,
  input  logic        ctl_rd_ack,
  output logic [21:0] ctl_addr,
  output logic [15:0] ctl_wdata,
  input  logic [15:0] ctl_rdata,
  input  logic        ctl_init_done,
  output logic        dqm_h,
  output logic        dqm_l,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, REQ, ACKDLY, DONE, DRAIN} state_t;
  localparam state_t POST = (ACK_DELAY == 1) ? DONE : ACKDLY;
  state_t state;
  logic [3:0] rcnt;
  logic [2:0] dcnt;
  logic [9:0] tcnt;
  logic we_l, ack_m, tmo, req;
  assign req = ctl_wr_req | ctl_rd_req;
  assign ack_m = we_l ? ctl_wr_ack : ctl_rd_ack;
  assign tmo = tcnt == 10'(TIMEOUT - 1);
  assign sdram_ack = (state == DONE) && sdram_stb;
  always_ff @(posedge clk_p)
    if (sdram_reset) begin
      rcnt <= '0;
      ctl_rst_n <= 1'b0;
      sdram_ready <= 1'b0;
    end else begin
      if (!ctl_rst_n) begin
        if (rcnt == 4'(RST_DELAY)) ctl_rst_n <= 1'b1;
        else rcnt <= rcnt + 4'd1;
      end
      sdram_ready <= ctl_rst_n & ctl_init_done;
    end
  always_ff @(posedge clk_p)
    if (sdram_reset) begin
      state <= IDLE;
      dcnt <= '0;
      tcnt <= '0;
      we_l <= 1'b0;
      sdram_dat <= '0;
      ctl_wr_req <= 1'b0;
      ctl_rd_req <= 1'b0;
      ctl_addr <= '0;
      ctl_wdata <= '0;
      dqm_h <= 1'b0;
      dqm_l <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (sdram_stb && sdram_ready) begin
          state <= REQ;
          ctl_addr <= {1'b0, sdram_adr};
          ctl_wdata <= sdram_out;
          we_l <= sdram_we;
          dqm_h <= sdram_we & ~sdram_sel[1];
          dqm_l <= sdram_we & ~sdram_sel[0];
          ctl_wr_req <= sdram_we;
          ctl_rd_req <= ~sdram_we;
          tcnt <= '0;
        end
        REQ: begin
          if (ctl_rd_ack && !we_l) sdram_dat <= ctl_rdata;
          if (ack_m || tmo) begin
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            dcnt <= '0;
            state <= sdram_stb ? POST : DRAIN;
            if (!ack_m) begin
              timeout_err <= 1'b1;
              if (!we_l) sdram_dat <= 16'hFFFF;
            end
          end else begin
            tcnt <= tcnt + 10'd1;
            if (!sdram_stb) state <= DRAIN;
          end
        end
        ACKDLY: if (!sdram_stb) state <= DRAIN;
          else if (dcnt == 3'(ACK_DELAY - 2)) state <= DONE;
          else dcnt <= dcnt + 3'd1;
        DONE: if (!sdram_stb) state <= IDLE;
        DRAIN: if (!req || ack_m || tmo) begin
          ctl_wr_req <= 1'b0;
          ctl_rd_req <= 1'b0;
          state <= IDLE;
        end else tcnt <= tcnt + 10'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_bus_bridge.sv
// tb_sdram_bus_bridge: randomized bench with a memory-level controller model and bus-level shadow memory
module tb_sdram_bus_bridge;
  localparam int RST_DELAY = 3, ACK_DELAY = 2, TIMEOUT = 15;
  logic clk_p = 1'b0, sdram_reset = 1'b1, sdram_stb = 1'b0, sdram_we = 1'b0;
  logic [1:0] sdram_sel = '0;
  logic [20:0] sdram_adr = '0;
  logic [15:0] sdram_out = '0, ctl_rdata = '0;
  logic ctl_wr_ack = 1'b0, ctl_rd_ack = 1'b0, ctl_init_done = 1'b0;
  logic [15:0] sdram_dat, ctl_wdata;
  logic [21:0] ctl_addr;
  logic sdram_ack, sdram_ready, ctl_rst_n, ctl_wr_req, ctl_rd_req, dqm_h, dqm_l, timeout_err;
  logic [15:0] mem [logic [20:0]];
  logic [15:0] shadow [logic [20:0]];
  logic [20:0] pool [8];
  int n_chk = 0, n_pass = 0;
  sdram_bus_bridge #(.RST_DELAY(RST_DELAY), .ACK_DELAY(ACK_DELAY), .TIMEOUT(TIMEOUT)) dut (
    .clk_p(clk_p), .sdram_reset(sdram_reset), .sdram_stb(sdram_stb), .sdram_we(sdram_we),
    .sdram_sel(sdram_sel), .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
    .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .ctl_rst_n(ctl_rst_n), .ctl_wr_req(ctl_wr_req),
    .ctl_rd_req(ctl_rd_req), .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata), .ctl_init_done(ctl_init_done), .dqm_h(dqm_h),
    .dqm_l(dqm_l), .timeout_err(timeout_err)
  );
  always #5 clk_p = ~clk_p;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk_p);
    #2;
  endtask
  function automatic logic [15:0] mem_rd(input logic [20:0] a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction
  function automatic logic [15:0] sh_rd(input logic [20:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0;
  endfunction
  task automatic do_reset();
    int n;
    sdram_reset = 1'b1;
    sdram_stb = 1'b0;
    ctl_wr_ack = 1'b0;
    ctl_rd_ack = 1'b0;
    ctl_init_done = 1'b0;
    step();
    step();
    check("rst_ctl_rst_n", ctl_rst_n, 0);
    check("rst_flags", {sdram_ack, sdram_ready, ctl_wr_req, ctl_rd_req, dqm_h, dqm_l, timeout_err}, 0);
    check("rst_addr", ctl_addr, 0);
    check("rst_data", {sdram_dat, ctl_wdata}, 0);
    sdram_reset = 1'b0;
    n = 0;
    while (!ctl_rst_n && n < 20) begin
      step();
      n++;
    end
    check("rst_delay", n, RST_DELAY + 1);
    step();
    step();
    ctl_init_done = 1'b1;
    check("ready_lag", sdram_ready, 0);
    step();
    check("ready", sdram_ready, 1);
  endtask
  // mode 0: normal, 1: stb dropped in REQ (ack 5 cycles later), 2: stb dropped in ACKDLY
  task automatic txn(input bit we, input logic [1:0] sel, input logic [20:0] adr,
                     input logic [15:0] d, input int lat, input int mode);
    logic [15:0] exp_rd, old;
    logic [1:0] exp_dqm;
    int n;
    step();
    sdram_stb = 1'b1;
    sdram_we = we;
    sdram_sel = sel;
    sdram_adr = adr;
    sdram_out = d;
    exp_rd = sh_rd(adr);
    exp_dqm = we ? ~sel : 2'b00;
    if (we) shadow[adr] = {sel[1] ? d[15:8] : exp_rd[15:8], sel[0] ? d[7:0] : exp_rd[7:0]};
    step();
    check("wr_req", ctl_wr_req, we);
    check("rd_req", ctl_rd_req, !we);
    check("addr", ctl_addr, {1'b0, adr});
    check("dqm", {dqm_h, dqm_l}, exp_dqm);
    if (we) check("wdata", ctl_wdata, d);
    if (mode == 1) begin
      sdram_stb = 1'b0;
      repeat (5) begin
        step();
        check("drain_req", ctl_wr_req | ctl_rd_req, 1);
        check("drain_noack", sdram_ack, 0);
      end
    end else begin
      for (int i = 0; i < lat; i++) begin
        step();
        check("req_hold", ctl_wr_req | ctl_rd_req, 1);
      end
    end
    if (we) begin
      ctl_wr_ack = 1'b1;
      old = mem_rd(ctl_addr[20:0]);
      mem[ctl_addr[20:0]] = {dqm_h ? old[15:8] : ctl_wdata[15:8], dqm_l ? old[7:0] : ctl_wdata[7:0]};
    end else begin
      ctl_rd_ack = 1'b1;
      ctl_rdata = mem_rd(ctl_addr[20:0]);
    end
    step();
    ctl_wr_ack = 1'b0;
    ctl_rd_ack = 1'b0;
    check("req_drop", ctl_wr_req | ctl_rd_req, 0);
    if (mode != 0) begin
      sdram_stb = 1'b0;
      repeat (3) begin
        #1 check("abort_noack", sdram_ack, 0);
        step();
      end
      return;
    end
    n = 1;
    while (!sdram_ack && n < 10) begin
      step();
      n++;
    end
    check("ack_latency", n, ACK_DELAY);
    if (!we) check("rdata", sdram_dat, exp_rd);
    repeat ($urandom_range(0, 2)) begin
      step();
      check("ack_hold", sdram_ack, 1);
    end
    sdram_stb = 1'b0;
    #1 check("ack_drop", sdram_ack, 0);
  endtask
  task automatic tmo_read(input logic [20:0] adr);
    int n;
    step();
    sdram_stb = 1'b1;
    sdram_we = 1'b0;
    sdram_sel = 2'b11;
    sdram_adr = adr;
    step();
    n = 0;
    while (ctl_rd_req && n < 40) begin
      n++;
      step();
    end
    check("tmo_len", n, TIMEOUT);
    check("tmo_err", timeout_err, 1);
    check("tmo_dat", sdram_dat, 16'hFFFF);
    n = 1;
    while (!sdram_ack && n < 10) begin
      step();
      n++;
      check("tmo_pulse", timeout_err, 0);
    end
    check("tmo_ack_latency", n, ACK_DELAY);
    sdram_stb = 1'b0;
    #1 check("tmo_ack_drop", sdram_ack, 0);
  endtask
  task automatic reset_mid_write(input logic [20:0] adr);
    step();
    sdram_stb = 1'b1;
    sdram_we = 1'b1;
    sdram_sel = 2'b11;
    sdram_adr = adr;
    sdram_out = 16'hDEAD;
    step();
    check("mid_wr_req", ctl_wr_req, 1);
    step();
    sdram_reset = 1'b1;
    step();
    check("mid_wr_req_drop", ctl_wr_req, 0);
    check("mid_rst_n", ctl_rst_n, 0);
    check("mid_noack", sdram_ack, 0);
    do_reset();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) pool[i] = 21'(i * 37 + 1024);
    do_reset();
    mem[21'h012345] = 16'hA5C3;
    shadow[21'h012345] = 16'hA5C3;
    txn(1'b0, 2'b11, 21'h012345, 16'h0000, 1, 0);
    txn(1'b1, 2'b01, 21'h000100, 16'h00EE, 2, 0);
    txn(1'b0, 2'b11, 21'h000100, 16'h0000, 0, 0);
    txn(1'b1, 2'b11, 21'h000200, 16'h1234, 0, 1);
    txn(1'b0, 2'b11, 21'h000200, 16'h0000, 3, 0);
    tmo_read(21'h000300);
    reset_mid_write(21'h000400);
    txn(1'b0, 2'b11, 21'h000400, 16'h0000, 1, 0);
    for (int t = 0; t < 60; t++) begin
      int mode;
      mode = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)],
          16'($urandom), $urandom_range(0, 6), mode);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sdram_bus_bridge.md
Name: sdram_bus_bridge

Overview:
- Synchronous bridge between the kernel's SDRAM bus (stb/we/sel/ack) and the sdram_top controller (rd_req/wr_req/ack).
- Sits directly downstream of topboard and upstream of sdram_top.
- Generates the delayed controller reset, latches address/data/byte mask per transaction, drives DQM, captures read data and forms the delayed bus ack.
- All logic runs on one clock; no signal is used as a clock.

Parameters:
RST_DELAY, 3, clk_p cycles between sdram_reset deassertion and ctl_rst_n rising (1..15)
ACK_DELAY, 2, clk_p cycles from controller ack to sdram_ack (1..7)
TIMEOUT, 1023, max cycles waiting for controller ack before forced completion (10-bit counter)

Ports:
clk_p  in  1  100 MHz system clock, all logic on rising edge
sdram_reset  in  1  synchronous active-high reset
sdram_stb  in  1  bus transaction strobe
sdram_we  in  1  1=write, 0=read
sdram_sel  in  2  byte select: [1] high byte, [0] low byte
sdram_adr  in  21  word address [21:1]
sdram_out  in  16  write data from bus
sdram_dat  out  16  read data to bus
sdram_ack  out  1  transaction acknowledge
sdram_ready  out  1  SDRAM initialised and bridge usable
ctl_rst_n  out  1  controller reset, active low
ctl_wr_req  out  1  write request to controller
ctl_rd_req  out  1  read request to controller
ctl_wr_ack  in  1  controller write acknowledge
ctl_rd_ack  in  1  controller read acknowledge / read data valid
ctl_addr  out  22  controller word address, {1'b0, adr}
ctl_wdata  out  16  latched write data
ctl_rdata  in  16  controller read data
ctl_init_done  in  1  controller init complete
dqm_h  out  1  DRAM_UDQM drive
dqm_l  out  1  DRAM_LDQM drive
timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
Reset and outputs:
- While sdram_reset=1, all outputs are 0, except ctl_rst_n=0. ctl_addr, ctl_wdata and sdram_dat are 0. FSM goes to IDLE; the delay counter clears.
- After sdram_reset falls, the counter increments each cycle. ctl_rst_n goes to 1 on the cycle after the count reaches RST_DELAY. sdram_reset reasserting at any time restarts the sequence.
- sdram_ready is a register equal to ctl_rst_n & ctl_init_done, so it lags init_done by 1 cycle.

FSM: IDLE, REQ, ACKDLY, DONE, DRAIN.
- IDLE: when sdram_stb & sdram_ready:
  - latch adr, out, we;
  - set dqm_h/dqm_l = we ? ~sel[1]/~sel[0] : 0/0;
  - go to REQ.
- REQ: ctl_wr_req = we_l, ctl_rd_req = ~we_l, held until the matching ack.
  - On ctl_rd_ack, capture ctl_rdata into sdram_dat in the same edge.
  - On the matching ack, drop req the next cycle and load the delay counter. Go to ACKDLY if stb is still high, else to DRAIN.
  - The non-matching ack is ignored.
- ACKDLY: count ACK_DELAY-1 cycles, then go to DONE. Net latency is ACK_DELAY cycles from the controller ack to sdram_ack=1.
- DONE: sdram_ack = 1 while sdram_stb=1. When stb falls, sdram_ack drops in the same cycle (combinational AND with stb) and the FSM goes to IDLE. A new transaction needs at least one IDLE cycle.
- DRAIN: the bus abandoned the cycle (stb fell in REQ or ACKDLY).
  - Wait for any outstanding controller ack, then go to IDLE.
  - Never assert sdram_ack for an abandoned cycle.
  - stb falling in ACKDLY goes to DRAIN and immediately to IDLE.

Timeout and stability:
- The timeout counter runs in REQ. When it reaches TIMEOUT: drop req, pulse timeout_err for 1 cycle, set sdram_dat=16'hFFFF on reads, and go to ACKDLY (or DRAIN if stb is low).
- Latched address, data and DQM stay stable from leaving IDLE until re-entering IDLE.
- sdram_ready falling mid-transaction does not abort it. sdram_reset mid-transaction aborts immediately with no ack.

Test Plan:
1. Reset release: sdram_reset 1→0 with RST_DELAY=3 → ctl_rst_n rises exactly 4 cycles later; ctl_init_done=1 → sdram_ready=1 one cycle later.
2. Word read at adr 21'h012345: rd_req asserted the cycle after stb, ctl_addr=22'h012345. rd_ack with rdata=16'hA5C3 → sdram_dat=A5C3, sdram_ack high exactly 2 cycles after rd_ack, dqm_h/dqm_l=0.
3. Byte write: sel=2'b01, out=16'h00EE → wr_req asserted, dqm_h=1, dqm_l=0, ctl_wdata=00EE. sdram_ack follows wr_ack by 2 cycles and drops the same cycle stb falls.
4. Abort: stb drops while in REQ, then wr_ack arrives 5 cycles later → no sdram_ack, FSM returns to IDLE, next stb is serviced normally.
5. Timeout: TIMEOUT=15, read with no ack → rd_req drops after 15 cycles, timeout_err single pulse, sdram_dat=FFFF, sdram_ack after ACK_DELAY.
6. Reset mid-write: sdram_reset in REQ → wr_req=0 and ctl_rst_n=0 next cycle, sdram_ack never asserted, full RST_DELAY sequence repeats.
